fifo_operator: RTL and testbench
================================

FIFO_OPERATOR -- requirements
Module: fifo_operator

Interface
REQ-001 SHALL have parameter data_width, default 32, width of din and dout.
REQ-002 SHALL have parameter depth, default 4, number of storage entries; legal values are powers of two, minimum 2.
REQ-003 SHALL have parameter output_size, default 1, number of downstream consumers sharing dout.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_l  output  1  request to the upstream producer for one word.
REQ-007 SHALL have port ack_l  input  1  one-cycle upstream acknowledge; din is valid in that cycle.
REQ-008 SHALL have port din  input  data_width  upstream data.
REQ-009 SHALL have port req_r  input  output_size  level requests from downstream consumers.
REQ-010 SHALL have port ack_r  output  1  one-cycle acknowledge to all downstream consumers together.
REQ-011 SHALL have port dout  output  data_width  registered output word.
REQ-012 SHALL have port occupancy  output  log2(depth)+1  number of words currently stored.

Function
REQ-013 SHALL store words in a circular buffer with write pointer, read pointer and count; both pointers wrap from depth-1 to 0.
REQ-014 SHALL push din at any rising edge where ack_l=1: write din at the write pointer, advance the write pointer, count+1.
REQ-015 SHALL drive req_l 0 on the edge after an ack_l=1 sample; otherwise it drives req_l 1 when count<depth and 0 when count=depth.
REQ-016 SHALL never have more than one outstanding upstream request, so a push never occurs at count=depth; an ack_l at count=depth is ignored and causes no write.
REQ-017 SHALL pop when count>0, all req_r bits =1 and ack_r=0: set ack_r=1 for exactly one cycle, load dout from the read pointer, advance the read pointer, count-1.
REQ-018 SHALL return ack_r to 0 on the edge after any cycle with ack_r=1, so the minimum spacing between pops is 2 cycles.
REQ-019 SHALL hold dout unchanged between pops.
REQ-020 SHALL keep count unchanged on an edge with both a push and a pop; the pop reads the pre-edge head entry.
REQ-021 SHALL pop only entries already stored before the edge, giving no write-through.
- First-word latency: ack_l sampled at edge E makes count 1 after E; ack_r rises at E+1 if req_r is all ones.
REQ-022 SHALL drive occupancy equal to count.
REQ-023 SHALL preserve word order, with no loss or duplication, for any interleaving of ack_l and req_r.

Reset
REQ-024 SHALL, on a rising edge with rst=1, set req_l=0, ack_r=0, dout=0, count=0 and both pointers=0, overriding any push or pop in that cycle.
REQ-025 SHALL assert req_l on the first edge after rst falls, given count=0.
REQ-026 SHALL discard all stored words on a reset during operation; no pre-reset word appears on dout afterwards.

Verification
REQ-027 SHALL pass this case: producer counts 0,1,2,... and consumer req_r is held 1 -> dout on successive ack_r pulses is 0,1,2,...,99 with no gaps or repeats, and each ack_r is high for exactly 1 cycle.
REQ-028 SHALL pass this case: depth=4 and req_r=0 for 30 cycles -> exactly 4 ack_l accepted, occupancy=4, req_l=0; then req_r=1 -> dout 0,1,2,3,4,... in order.
REQ-029 SHALL pass this case: no ack_l ever after reset -> ack_r stays 0, occupancy=0, dout=0, req_l=1 from the second cycle after reset.
REQ-030 SHALL pass this case: at occupancy=2, ack_l and a pop on the same edge -> occupancy stays 2; the popped value is the older head word.
REQ-031 SHALL pass this case: rst pulsed at occupancy=3 -> next cycle occupancy=0, ack_r=0, dout=0, req_l=0; the next dout values come only from post-reset pushes.
REQ-032 SHALL pass this case: output_size=2, req_r=2'b01, occupancy=2 -> ack_r stays 0; req_r=2'b11 -> a single ack_r pulse and occupancy=1.

Source files
------------

// File: rtl/fifo_operator_if.sv
// Handshake bundle between the FIFO operator, its producer and its consumers.
interface fifo_operator_if #(
    parameter int data_width  = 32,
    parameter int depth       = 4,
    parameter int output_size = 1
);
    localparam int cw = $clog2(depth) + 1;

    logic                   req_l;
    logic                   ack_l;
    logic [data_width-1:0]  din;
    logic [output_size-1:0] req_r;
    logic                   ack_r;
    logic [data_width-1:0]  dout;
    logic [cw-1:0]          occupancy;

    modport master (
        output req_l, ack_r, dout, occupancy,
        input  ack_l, din, req_r
    );

    modport slave (
        input  req_l, ack_r, dout, occupancy,
        output ack_l, din, req_r
    );
endinterface

// File: rtl/fifo_operator.sv
// Circular-buffer FIFO between a req/ack producer and a set of level-request consumers.
module fifo_operator #(
    parameter int data_width  = 32,
    parameter int depth       = 4,
    parameter int output_size = 1
) (
    input  logic clk,
    input  logic rst,
    fifo_operator_if.master bus
);
    localparam int aw = $clog2(depth);
    localparam int cw = aw + 1;
    localparam logic [cw-1:0] full = cw'(depth);

    logic [data_width-1:0] mem [depth];
    logic [aw-1:0]         wp;
    logic [aw-1:0]         rp;
    logic [cw-1:0]         cnt;
    logic [cw-1:0]         cnt_nxt;
    logic                  push;
    logic                  pop;

    assign push = bus.ack_l && (cnt != full);
    assign pop  = (cnt != '0) && (&bus.req_r) && !bus.ack_r;

    always_comb begin
        cnt_nxt = cnt;
        if (push && !pop)
            cnt_nxt = cnt + 1'b1;
        else if (pop && !push)
            cnt_nxt = cnt - 1'b1;
    end

    // Storage has no reset; the pointers and count make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (!rst && push)
            mem[wp] <= bus.din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.req_l <= 1'b0;
            bus.ack_r <= 1'b0;
            bus.dout  <= '0;
            cnt       <= '0;
            wp        <= '0;
            rp        <= '0;
        end else begin
            if (push)
                wp <= wp + 1'b1;
            if (pop) begin
                bus.dout <= mem[rp];
                rp       <= rp + 1'b1;
            end
            bus.ack_r <= pop;
            cnt       <= cnt_nxt;
            // Drop the request for a cycle after each ack so only one is ever outstanding.
            if (bus.ack_l)
                bus.req_l <= 1'b0;
            else
                bus.req_l <= (cnt_nxt != full);
        end
    end

    assign bus.occupancy = cnt;
endmodule

// File: tb/tb_fifo_operator.sv
// Scoreboard bench for fifo_operator: expected words queued at drive time, compared on ack_r.
module tb_fifo_operator;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int OS    = 2;

    logic clk;
    logic rst;

    fifo_operator_if #(.data_width(DW), .depth(DEPTH), .output_size(OS)) bus ();

    fifo_operator #(.data_width(DW), .depth(DEPTH), .output_size(OS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks;
    int          errors;
    int          pops;
    int          accepted;
    int          p0;
    logic [31:0] q [$];
    logic [31:0] exp_dout;
    logic [31:0] val;
    logic        prev_ack;
    bit          prod_en;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.ack_r === 1'b1) begin
            check("ack_pulse", 64'(prev_ack), 64'(0));
            check("pop_avail", 64'(q.size() != 0), 64'(1));
            if (q.size() != 0)
                exp_dout = q.pop_front();
            pops++;
        end
        prev_ack = bus.ack_r;
        check("dout", 64'(bus.dout), 64'(exp_dout));
        check("occ", 64'(bus.occupancy), 64'(q.size()));
        if (prod_en) begin
            if (bus.req_l === 1'b1 && bus.ack_l == 1'b0) begin
                bus.ack_l = 1'b1;
                bus.din   = val;
                q.push_back(val);
                val++;
                accepted++;
            end else begin
                bus.ack_l = 1'b0;
            end
        end
    endtask

    task automatic manual_push(input logic [31:0] v);
        for (int i = 0; i < 10 && bus.req_l !== 1'b1; i++)
            tick();
        check("req_l_wait", 64'(bus.req_l), 64'(1));
        bus.ack_l = 1'b1;
        bus.din   = v;
        q.push_back(v);
        tick();
        bus.ack_l = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0; pops = 0; accepted = 0;
        exp_dout = '0; prev_ack = 1'b0; prod_en = 1'b0; val = '0;
        rst = 1'b1;
        bus.ack_l = 1'b0;
        bus.din   = '0;
        bus.req_r = '0;

        tick();
        tick();
        check("rst_req_l", 64'(bus.req_l), 64'(0));
        check("rst_ack_r", 64'(bus.ack_r), 64'(0));
        rst = 1'b0;
        tick();
        check("req_l_after_rst", 64'(bus.req_l), 64'(1));

        // Idle: no producer activity
        bus.req_r = 2'b11;
        repeat (10) tick();
        check("idle_req_l", 64'(bus.req_l), 64'(1));
        check("idle_ack_r", 64'(bus.ack_r), 64'(0));
        check("idle_pops", 64'(pops), 64'(0));

        // Fill with consumers stalled
        val = 32'hA000_0000;
        bus.req_r = 2'b00;
        prod_en = 1'b1;
        repeat (30) tick();
        prod_en = 1'b0;
        bus.ack_l = 1'b0;
        check("fill_accepted", 64'(accepted), 64'(4));
        check("fill_occ", 64'(bus.occupancy), 64'(4));
        check("fill_req_l", 64'(bus.req_l), 64'(0));

        // Ack while full must not write
        bus.ack_l = 1'b1;
        bus.din   = 32'hDEAD_BEEF;
        tick();
        bus.ack_l = 1'b0;
        check("full_ignore_occ", 64'(bus.occupancy), 64'(4));
        tick();

        // Drain to two, then partial consumer request
        bus.req_r = 2'b11;
        for (int i = 0; i < 20 && q.size() > 2; i++)
            tick();
        bus.req_r = 2'b01;
        check("drain_occ", 64'(bus.occupancy), 64'(2));
        p0 = pops;
        repeat (5) tick();
        check("partial_no_pop", 64'(pops - p0), 64'(0));
        check("partial_occ", 64'(bus.occupancy), 64'(2));
        bus.req_r = 2'b11;
        tick();
        bus.req_r = 2'b01;
        check("single_ack_r", 64'(bus.ack_r), 64'(1));
        check("single_occ", 64'(bus.occupancy), 64'(1));
        repeat (3) tick();
        check("single_pops", 64'(pops - p0), 64'(1));

        // Simultaneous push and pop at occupancy two
        manual_push(32'hB000_0001);
        for (int i = 0; i < 10 && bus.req_l !== 1'b1; i++)
            tick();
        check("simul_req_l", 64'(bus.req_l), 64'(1));
        check("simul_pre_occ", 64'(bus.occupancy), 64'(2));
        bus.ack_l = 1'b1;
        bus.din   = 32'hB000_0002;
        q.push_back(32'hB000_0002);
        bus.req_r = 2'b11;
        tick();
        bus.ack_l = 1'b0;
        bus.req_r = 2'b01;
        check("simul_occ", 64'(bus.occupancy), 64'(2));
        check("simul_dout", 64'(bus.dout), 64'(32'hA000_0003));

        // Reset with three stored words
        manual_push(32'hB000_0003);
        check("pre_rst_occ", 64'(bus.occupancy), 64'(3));
        rst = 1'b1;
        bus.ack_l = 1'b0;
        bus.req_r = 2'b11;
        q.delete();
        exp_dout = '0;
        tick();
        check("mid_rst_occ", 64'(bus.occupancy), 64'(0));
        check("mid_rst_ack_r", 64'(bus.ack_r), 64'(0));
        check("mid_rst_dout", 64'(bus.dout), 64'(0));
        check("mid_rst_req_l", 64'(bus.req_l), 64'(0));
        rst = 1'b0;

        // Streaming 0..99 with consumers always requesting
        val = '0;
        p0 = pops;
        prod_en = 1'b1;
        for (int i = 0; i < 2000 && (pops - p0) < 100; i++)
            tick();
        check("stream_pops", 64'(pops - p0), 64'(100));
        check("stream_last", 64'(bus.dout), 64'(99));
        prod_en = 1'b0;
        bus.ack_l = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
